// File: rtl/vector_dot_product_pipelined_param_pkg.sv
// rtl/vector_dot_product_pipelined_param_pkg.sv - shared defaults, width helper and stage sideband type.
// DOT_ACCUM_EN is the optional group-accumulate build switch.
package dot_pkg;

  localparam int DOT_N_ELEM = 8;
  localparam int DOT_ELEM_W = 8;

  function automatic int dot_out_w(input int n, input int w);
    return 2 * w + $clog2(n);
  endfunction

  typedef struct packed {
    logic valid;
    logic is_signed;
    logic last;
  } dot_sb_t;

endpackage

// File: rtl/vector_dot_product_pipelined_param_if.sv
// rtl/vector_dot_product_pipelined_param_if.sv - operand/result handshake bundle.
// DOT_ACCUM_EN adds in_last and widens dot_product to the accumulator width.
interface dot_if #(
  parameter int N_ELEM = dot_pkg::DOT_N_ELEM,
  parameter int ELEM_W = dot_pkg::DOT_ELEM_W
);
  localparam int OUT_W = dot_pkg::dot_out_w(N_ELEM, ELEM_W);
`ifdef DOT_ACCUM_EN
  localparam int RES_W = OUT_W + 8;
`else
  localparam int RES_W = OUT_W;
`endif

  logic                           in_valid;
  logic                           in_ready;
  logic                           in_signed;
  logic [N_ELEM-1:0][ELEM_W-1:0]  vec_a;
  logic [N_ELEM-1:0][ELEM_W-1:0]  vec_b;
  logic                           out_valid;
  logic                           out_ready;
  logic [RES_W-1:0]               dot_product;
`ifdef DOT_ACCUM_EN
  logic                           in_last;

  modport master (output in_valid, in_signed, vec_a, vec_b, in_last, out_ready,
                  input  in_ready, out_valid, dot_product);
  modport slave  (input  in_valid, in_signed, vec_a, vec_b, in_last, out_ready,
                  output in_ready, out_valid, dot_product);
`else
  modport master (output in_valid, in_signed, vec_a, vec_b, out_ready,
                  input  in_ready, out_valid, dot_product);
  modport slave  (input  in_valid, in_signed, vec_a, vec_b, out_ready,
                  output in_ready, out_valid, dot_product);
`endif

endinterface

// File: rtl/vector_dot_product_pipelined_param_adder_level.sv
// rtl/vector_dot_product_pipelined_param_adder_level.sv - one registered pairwise-reduction level.
// Sums adjacent pairs, extending each operand by one bit according to the beat's mode.
module dot_adder_level
  import dot_pkg::*;
#(
  parameter int IN_CNT = 8,
  parameter int IN_W   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  dot_sb_t                           sb_i,
  input  logic [IN_CNT*IN_W-1:0]            data_i,
  output dot_sb_t                           sb_o,
  output logic [(IN_CNT/2)*(IN_W+1)-1:0]    data_o
);
  localparam int OUT_CNT = IN_CNT / 2;
  localparam int OUT_W   = IN_W + 1;

  dot_sb_t                    sb_q;
  logic [OUT_CNT*OUT_W-1:0]   sum_d;
  logic [OUT_CNT*OUT_W-1:0]   sum_q;

  function automatic logic [OUT_W-1:0] ext(input logic [IN_W-1:0] x, input logic s);
    return {s & x[IN_W-1], x};
  endfunction

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < OUT_CNT; i++) begin
      sum_d[i*OUT_W +: OUT_W] = ext(data_i[(2*i)*IN_W +: IN_W], sb_i.is_signed)
                              + ext(data_i[(2*i+1)*IN_W +: IN_W], sb_i.is_signed);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_q  <= '0;
      sum_q <= '0;
    end else if (en) begin
      sb_q  <= sb_i;
      sum_q <= sum_d;
    end
  end

  assign sb_o   = sb_q;
  assign data_o = sum_q;

endmodule

// File: rtl/vector_dot_product_pipelined_param.sv
// rtl/vector_dot_product_pipelined_param.sv - pipelined dot-product: S0 operands, S1 products, L adder levels, output reg.
// DOT_ACCUM_EN turns the output stage into a group accumulator closed by in_last.
module vector_dot_product_pipelined_param
  import dot_pkg::*;
#(
  parameter int N_ELEM = DOT_N_ELEM,
  parameter int ELEM_W = DOT_ELEM_W
) (
  input logic   clk,
  input logic   rst,
  dot_if.slave  bus
);
  localparam int L      = $clog2(N_ELEM);
  localparam int OUT_W  = dot_out_w(N_ELEM, ELEM_W);
  localparam int PROD_W = 2 * ELEM_W;
`ifdef DOT_ACCUM_EN
  localparam int RES_W  = OUT_W + 8;
`else
  localparam int RES_W  = OUT_W;
`endif

  logic stall, en, accept, beat_last;
  logic out_valid_q;
  logic [RES_W-1:0] dot_d, dot_q;

  // Whole pipeline freezes while the output register holds an unaccepted result.
  assign stall        = out_valid_q && !bus.out_ready;
  assign en           = !stall;
  assign accept       = bus.in_valid && en;
  assign bus.in_ready = en;

`ifdef DOT_ACCUM_EN
  assign beat_last = bus.in_last;
`else
  assign beat_last = 1'b1;
`endif

  dot_sb_t                        s0_sb_q, s1_sb_q;
  logic [N_ELEM-1:0][ELEM_W-1:0]  a_q, b_q;
  logic [N_ELEM*PROD_W-1:0]       prod_d, prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_sb_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (en) begin
      s0_sb_q <= '{valid: accept, is_signed: bus.in_signed, last: beat_last};
      a_q     <= bus.vec_a;
      b_q     <= bus.vec_b;
    end
  end

  function automatic logic [PROD_W-1:0] widen(input logic [ELEM_W-1:0] x, input logic s);
    return {{ELEM_W{s & x[ELEM_W-1]}}, x};
  endfunction

  // Extending both operands to PROD_W makes the truncated product correct in either mode.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      prod_d[i*PROD_W +: PROD_W] = widen(a_q[i], s0_sb_q.is_signed)
                                 * widen(b_q[i], s0_sb_q.is_signed);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sb_q <= '0;
      prod_q  <= '0;
    end else if (en) begin
      s1_sb_q <= s0_sb_q;
      prod_q  <= prod_d;
    end
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int IN_CNT = N_ELEM >> k;
    localparam int IN_W   = PROD_W + k;

    dot_sb_t                              sb_in, sb_out;
    logic [IN_CNT*IN_W-1:0]               din;
    logic [(IN_CNT/2)*(IN_W+1)-1:0]       dout;

    if (k == 0) begin : g_first
      assign sb_in = s1_sb_q;
      assign din   = prod_q;
    end else begin : g_next
      assign sb_in = g_lvl[k-1].sb_out;
      assign din   = g_lvl[k-1].dout;
    end

    dot_adder_level #(
      .IN_CNT (IN_CNT),
      .IN_W   (IN_W)
    ) u_level (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .sb_i   (sb_in),
      .data_i (din),
      .sb_o   (sb_out),
      .data_o (dout)
    );
  end

  dot_sb_t          tree_sb;
  logic [OUT_W-1:0] tree;
  assign tree_sb = g_lvl[L-1].sb_out;
  assign tree    = g_lvl[L-1].dout;

`ifdef DOT_ACCUM_EN
  logic [RES_W-1:0] acc_d, acc_q, acc_sum;

  always_comb begin
    acc_sum = acc_q + {{(RES_W-OUT_W){tree_sb.is_signed & tree[OUT_W-1]}}, tree};
    acc_d   = acc_q;
    dot_d   = dot_q;
    if (tree_sb.valid) begin
      if (tree_sb.last) begin
        dot_d = acc_sum;
        acc_d = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end
`else
  always_comb begin
    dot_d = dot_q;
    if (tree_sb.valid) begin
      dot_d = tree;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      dot_q       <= '0;
    end else if (en) begin
      out_valid_q <= tree_sb.valid && tree_sb.last;
      dot_q       <= dot_d;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.dot_product = dot_q;

endmodule
